// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU dispatch block.
// Holds the accepted opcode values, the bit positions of the RV32I
// instruction fields the dispatcher decodes, the dispatcher FSM state
// type and a helper that builds the sign-extended I-type immediate.
package alu_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;  // register-register ALU ops
  localparam logic [6:0] OP_I = 7'b0010011;  // register-immediate ALU ops

  // Field positions inside the 32-bit instruction word.
  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int IMM_LSB    = 20;
  localparam int ALT_BIT    = 30;  // selects SUB / SRA variants

  // funct3 of the right-shift group; its alternate bit is meaningful
  // for both R-type and I-type encodings.
  localparam logic [2:0] F3_SR = 3'b101;

  typedef enum logic {
    ST_IDLE,
    ST_EXEC
  } state_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:IMM_LSB]};
  endfunction

endpackage

// File: rtl/regfile32.sv
// regfile32 -- 32 x 32-bit architectural register file.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   we, waddr, wdata    : synchronous write port (writes to x0 dropped)
//   raddr1/rdata1       : asynchronous read port 1
//   raddr2/rdata2       : asynchronous read port 2
//   dbg_addr/dbg_data   : asynchronous debug read port
// x0 always reads as zero regardless of what the storage holds.
module regfile32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  logic [31:0] mem [32];

  // NOTE: the whole array is reset because clearing every register is
  // architecturally visible; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1   == 5'd0) ? '0 : mem[raddr1];
  assign rdata2   = (raddr2   == 5'd0) ? '0 : mem[raddr2];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch -- two-cycle RV32I ALU instruction dispatcher.
// Accepts an R-type or I-type ALU instruction in IDLE, registers the ALU
// op code and operands, and in EXEC writes the external combinational
// ALU result back into the register file.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   instr_valid/instr_ready : instruction handshake (ready only in IDLE)
//   instr                   : RV32I instruction word
//   alu_op, alu_rv1, alu_rv2: registered ALU op code and operands
//   alu_rvout               : combinational ALU result
//   done                    : pulse during the writeback (EXEC) cycle
//   illegal                 : pulse the cycle after a rejected opcode
//   dbg_addr/dbg_data       : combinational register file peek
module alu_dispatch
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [5:0]  alu_op,
  output logic [31:0] alu_rv1,
  output logic [31:0] alu_rv2,
  input  logic [31:0] alu_rvout,
  output logic        done,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  state_t      state;
  state_t      next_state;
  logic [4:0]  rd;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  logic        accept;
  logic        is_rtype;
  logic        is_itype;
  logic        alt;
  logic [2:0]  funct3;
  logic [5:0]  op_d;
  logic [31:0] rv2_d;

  assign accept = (state == ST_IDLE) && instr_valid;
  assign funct3 = instr[FUNCT3_LSB +: 3];

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    is_rtype = 1'b0;
    is_itype = 1'b0;
    alt      = 1'b0;
    op_d     = '0;
    rv2_d    = '0;
    is_rtype = (instr[OPCODE_LSB +: 7] == OP_R);
    is_itype = (instr[OPCODE_LSB +: 7] == OP_I);
    // Only SUB/SRA (R-type) and SRAI use bit 30; for other I-type ops it
    // is just an immediate bit and must not alter the op code.
    if (is_rtype || (funct3 == F3_SR)) begin
      alt = instr[ALT_BIT];
    end
    op_d  = {is_itype, is_rtype, funct3, alt};
    rv2_d = is_rtype ? rs2_data : imm_i(instr);
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept && (is_rtype || is_itype)) next_state = ST_EXEC;
      ST_EXEC: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      alu_op  <= '0;
      alu_rv1 <= '0;
      alu_rv2 <= '0;
      rd      <= '0;
      illegal <= 1'b0;
    end else begin
      state   <= next_state;
      illegal <= accept && !(is_rtype || is_itype);
      if (accept && (is_rtype || is_itype)) begin
        alu_op  <= op_d;
        alu_rv1 <= rs1_data;
        alu_rv2 <= rv2_d;
        rd      <= instr[RD_LSB +: 5];
      end
    end
  end

  assign instr_ready = (state == ST_IDLE);
  // Gating with reset drops both the pulse and the writeback when reset
  // lands in the EXEC cycle.
  assign done = (state == ST_EXEC) && !reset;

  regfile32 u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (done),
    .waddr    (rd),
    .wdata    (alu_rvout),
    .raddr1   (instr[RS1_LSB +: 5]),
    .rdata1   (rs1_data),
    .raddr2   (instr[RS2_LSB +: 5]),
    .rdata2   (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1; one clock; reset is synchronous and active-high.
REQ-003 SHALL have port instr_valid, input, 1, instruction word present.
REQ-004 SHALL have port instr_ready, output, 1, block can accept an instruction.
REQ-005 SHALL have port instr, input, 32, RV32I instruction word.
REQ-006 SHALL have port alu_op, output, 6, ALU op code.
REQ-007 SHALL have port alu_rv1, output, 32, ALU first operand.
REQ-008 SHALL have port alu_rv2, output, 32, ALU second operand.
REQ-009 SHALL have port alu_rvout, input, 32, combinational ALU result.
REQ-010 SHALL have port done, output, 1, one-cycle pulse during the writeback cycle.
REQ-011 SHALL have port illegal, output, 1, one-cycle pulse on a rejected instruction.
REQ-012 SHALL have port dbg_addr, input, 5, debug register select.
REQ-013 SHALL have port dbg_data, output, 32, combinational read of rf[dbg_addr].

Function
REQ-014 SHALL hold 32x32 register file; x0 reads 0 always, writes to x0 discarded.
REQ-015 SHALL implement FSM IDLE -> EXEC -> IDLE; instr_ready=1 only in IDLE.
REQ-016 IDLE, instr_valid=1: SHALL decode instr, register alu_op/alu_rv1/alu_rv2/rd, go to EXEC.
REQ-017 SHALL accept opcode 0110011 (R-type) and 0010011 (I-type ALU); any other opcode -> illegal=1 next cycle, stay IDLE, no register write.
REQ-018 alu_op SHALL be {is_itype, is_rtype, funct3 instr[14:12], b0}; b0=instr[30] when R-type or funct3=101, else 0.
REQ-019 alu_rv1 SHALL be rf[instr[19:15]]; alu_rv2 SHALL be rf[instr[24:20]] for R-type, sign-extended instr[31:20] for I-type.
REQ-020 EXEC: done=1; at end of cycle rf[rd]<=alu_rvout (rd=instr[11:7]) unless rd=0; next state IDLE.
REQ-021 alu_op/alu_rv1/alu_rv2 SHALL hold stable through EXEC and retain values in IDLE until next accept.
REQ-022 Back-to-back dependent instructions SHALL read the value written in the preceding EXEC (write precedes next IDLE read; no forwarding required).
REQ-023 Throughput SHALL be one instruction per 2 cycles; instr_valid without instr_ready SHALL be ignored.
REQ-024 illegal and done SHALL never assert in the same cycle.

Reset
REQ-025 reset SHALL force IDLE, clear all 32 registers, and drive alu_op=0, alu_rv1=0, alu_rv2=0, done=0, illegal=0, instr_ready=1 next cycle.
REQ-026 reset asserted in EXEC SHALL suppress that cycle's register write and done pulse.

Structure
REQ-027 Shared package alu_pkg SHALL hold opcode constants (OP_R, OP_I), op-field bit positions, and the FSM state type.
REQ-028 Register file SHALL be sub-module regfile32: two async read ports plus debug read, one sync write port, x0 hardwired.

Verification
REQ-029 Bench SHALL connect alu_op/rv1/rv2/rvout to the team's combinational ALU and check via dbg port.
REQ-030 Reset; ADDI x1,x0,5 (0x00500093) -> alu_op=6'b100000, rv1=0, rv2=5, done one cycle later, x1=5.
REQ-031 x1=5, x2=7 (ADDI); SUB x3,x1,x2 (0x402081B3) -> alu_op=6'b010001, x3=0xFFFFFFFE.
REQ-032 SRAI x4,x3,1 (0x4011D213) -> alu_op=6'b101011, rv2=0x00000401, x4=0xFFFFFFFF.
REQ-033 ADDI x0,x0,9 (0x00900013) -> done pulses, x0 reads 0; load word 0x00002003 -> illegal pulse, no done, instr_ready=1 next cycle, all registers unchanged.
REQ-034 Reset asserted during EXEC of ADDI x5,x0,3 -> x5=0, done=0, FSM in IDLE after reset.
